layer_sequencer: RTL and testbench

//  Frame-level controller for the fully-connected layer chain (layer0, layer1, ...).

---
 rtl/layer_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer
// Frame-level controller for the fully-connected layer chain. It accepts one
// frame via frameValid/frameReady and then walks the layers in order. For each
// layer it gives a one-cycle clear pulse, holds the layer's enable until that
// layer reports done, and leaves a one-cycle gap before the next layer starts.
// It presents the result with a resultValid/resultReady handshake and counts
// the frames that complete.
//
// Optional feature macro: TIMEOUT_EN
//   Defined   : each layer's RUN phase is limited to timeoutCycles cycles. When
//               the limit is hit the sequencer parks in ERROR (error=1) until
//               errorClear is asserted.
//   Undefined : RUN waits for done indefinitely, error is tied low and
//               errorClear is ignored.
//
// All outputs are decoded from registered state only (state, activeLayer,
// frameCount). Reset is synchronous and active-low.

`default_nettype none

module layer_sequencer #(
  parameter int numLayers     = 3,
  parameter int timeoutCycles = 1024,
  parameter int countWidth    = 16,
  localparam int layerWidth   = (numLayers > 1) ? $clog2(numLayers) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameValid,
  output logic                  frameReady,
  output logic [numLayers-1:0]  layerClear,
  output logic [numLayers-1:0]  layerEnable,
  input  logic [numLayers-1:0]  layerDone,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic                  busy,
  output logic [layerWidth-1:0] activeLayer,
  output logic [countWidth-1:0] frameCount,
  output logic                  error,
  input  logic                  errorClear
);

  // Sequencer phases. ERROR exists only when the run timeout is built in.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    GAP,
    HOLD
`ifdef TIMEOUT_EN
    , ERROR
`endif
  } stateType;

  localparam logic [layerWidth-1:0] lastLayerIndex = layerWidth'(numLayers - 1);

  stateType             state;
  stateType             nextState;
  logic [numLayers-1:0] layerOneHot;
  logic                 activeDone;
  logic                 onLastLayer;

`ifdef TIMEOUT_EN
  localparam int runWidth = $clog2(timeoutCycles);
  // The last legal RUN cycle, counted from zero. If done has not arrived by
  // then, the layer has timed out.
  localparam logic [runWidth-1:0] runLimit = runWidth'(timeoutCycles - 1);

  logic [runWidth-1:0] runCount;
  logic                runExpired;
`endif

  // Only the active layer's done bit matters. Done bits from any other layer
  // never reach the FSM.
  assign activeDone  = layerDone[activeLayer];
  assign onLastLayer = (activeLayer == lastLayerIndex);

  // One-hot decode of the active layer index. It drives both clear and enable.
  always_comb begin
    for (int k = 0; k < numLayers; k++) begin
      layerOneHot[k] = (activeLayer == layerWidth'(k));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of process ordering.
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Done wins over the timeout when both happen in the same cycle.
  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      IDLE: begin
        if (frameValid) begin
          nextState = CLEAR;
        end
      end
      CLEAR: begin
        nextState = RUN;
      end
      RUN: begin
        if (activeDone) begin
          nextState = onLastLayer ? HOLD : GAP;
        end
`ifdef TIMEOUT_EN
        else if (runExpired) begin
          nextState = ERROR;
        end
`endif
      end
      GAP: begin
        nextState = CLEAR;
      end
      HOLD: begin
        if (resultReady) begin
          nextState = IDLE;
        end
      end
`ifdef TIMEOUT_EN
      ERROR: begin
        if (errorClear) begin
          nextState = IDLE;
        end
      end
`endif
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Output decode from the registered state and the layer index
  always_comb begin
    frameReady  = 1'b0;
    layerClear  = '0;
    layerEnable = '0;
    resultValid = 1'b0;
    busy        = 1'b1;
    error       = 1'b0;
    case (state)
      IDLE: begin
        frameReady = 1'b1;
        busy       = 1'b0;
      end
      CLEAR: begin
        layerClear = layerOneHot;
      end
      RUN: begin
        layerEnable = layerOneHot;
      end
      HOLD: begin
        resultValid = 1'b1;
      end
`ifdef TIMEOUT_EN
      ERROR: begin
        error = 1'b1;
      end
`endif
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Layer index. It advances when a gap ends and returns to zero whenever the
  // sequencer heads back to IDLE, so every frame starts at layer 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      activeLayer <= '0;
    end else if (state == GAP) begin
      activeLayer <= activeLayer + layerWidth'(1);
    end else if (nextState == IDLE) begin
      activeLayer <= '0;
    end
  end

  // Completed-frame counter. It counts the result handshake and wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frameCount <= '0;
    end else if ((state == HOLD) && resultReady) begin
      frameCount <= frameCount + countWidth'(1);
    end
  end

`ifdef TIMEOUT_EN
  assign runExpired = (runCount == runLimit);

  // Run-cycle counter. It is zeroed during CLEAR, so the first RUN cycle reads 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      runCount <= '0;
    end else if (state == CLEAR) begin
      runCount <= '0;
    end else if (state == RUN) begin
      runCount <= runCount + runWidth'(1);
    end
  end
`else
  // Without the timeout, errorClear has no function.
  logic unusedErrorClear;
  assign unusedErrorClear = errorClear;
`endif

  // At most one layer is enabled at a time.
  assertEnableOneHot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(layerEnable));

  // A layer is never cleared and enabled in the same cycle.
  assertClearEnableExclusive : assert property (@(posedge clk) disable iff (!reset)
    !((|layerClear) && (|layerEnable)));

  // frameReady is only offered while the sequencer is idle.
  assertReadyOnlyIdle : assert property (@(posedge clk) disable iff (!reset)
    !(frameReady && busy));

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
// Directed bench for layer_sequencer with numLayers=3, timeoutCycles=16 and
// countWidth=2, so frameCount wraps after four frames. Inputs are driven 1 ns
// after each rising edge. Outputs for that cycle are checked at the same point.
// The variable "cycle" numbers the clock periods from the first edge.

module tb_layer_sequencer;

  localparam int numLayers     = 3;
  localparam int timeoutCycles = 16;
  localparam int countWidth    = 2;

  logic                  clk         = 1'b0;
  logic                  reset       = 1'b0;
  logic                  frameValid  = 1'b0;
  logic                  resultReady = 1'b0;
  logic                  errorClear  = 1'b0;
  logic [numLayers-1:0]  layerDone   = '0;
  logic                  frameReady;
  logic                  resultValid;
  logic                  busy;
  logic                  error;
  logic [numLayers-1:0]  layerClear;
  logic [numLayers-1:0]  layerEnable;
  logic [1:0]            activeLayer;
  logic [countWidth-1:0] frameCount;

  int assertionCount = 0;
  int failureCount   = 0;
  int cycle          = 0;
  int acceptCycle    = 0;

  layer_sequencer #(
    .numLayers    (numLayers),
    .timeoutCycles(timeoutCycles),
    .countWidth   (countWidth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frameValid (frameValid),
    .frameReady (frameReady),
    .layerClear (layerClear),
    .layerEnable(layerEnable),
    .layerDone  (layerDone),
    .resultValid(resultValid),
    .resultReady(resultReady),
    .busy       (busy),
    .activeLayer(activeLayer),
    .frameCount (frameCount),
    .error      (error),
    .errorClear (errorClear)
  );

  always #5 clk = ~clk;

  // Stops a stuck run instead of letting it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failureCount++;
      $display("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic checkIdle(input string tag, input int expectedCount);
    check({tag, ".frameReady"},  frameReady,  1);
    check({tag, ".busy"},        busy,        0);
    check({tag, ".layerEnable"}, layerEnable, 0);
    check({tag, ".layerClear"},  layerClear,  0);
    check({tag, ".resultValid"}, resultValid, 0);
    check({tag, ".activeLayer"}, activeLayer, 0);
    check({tag, ".error"},       error,       0);
    check({tag, ".frameCount"},  frameCount,  expectedCount);
  endtask

  // Present a frame in the current (IDLE) cycle. On return the DUT is in CLEAR.
  task automatic acceptFrame();
    check("acceptReady", frameReady, 1);
    frameValid  = 1'b1;
    acceptCycle = cycle;
    step();
    frameValid = 1'b0;
  endtask

  // Starts in the CLEAR cycle of layer k. Runs runCycles cycles and asserts done
  // on the last one. If stray is nonzero, every done bit is pulsed during CLEAR
  // and the stray bits are pulsed in the first RUN cycle; both must be ignored.
  // Returns in the next CLEAR, or in HOLD after the last layer.
  task automatic runLayer(input int k, input int runCycles, input logic [2:0] stray);
    logic [2:0] oneHot;
    oneHot = 3'b001 << k;
    check("clearPulse",      layerClear,  oneHot);
    check("clearEnableLow",  layerEnable, 0);
    check("clearLayerIndex", activeLayer, k);
    check("clearNotReady",   frameReady,  0);
    if (stray != 3'b000) layerDone = 3'b111;
    step();
    layerDone = '0;
    for (int i = 0; i < runCycles; i++) begin
      check("runEnable",   layerEnable, oneHot);
      check("runClearLow", layerClear,  0);
      if (i == runCycles - 1) layerDone = oneHot;
      else if (i == 0)        layerDone = stray;
      step();
      layerDone = '0;
    end
    if (k < numLayers - 1) begin
      check("gapEnableLow", layerEnable, 0);
      check("gapClearLow",  layerClear,  0);
      check("gapBusy",      busy,        1);
      step();
    end
  endtask

  // Starts in HOLD. Keeps resultReady low for waitCycles while frameValid is
  // held high (it must be ignored), then completes the handshake.
  task automatic finishFrame(input int waitCycles, input int expectedCount);
    for (int i = 0; i < waitCycles; i++) begin
      check("holdValid",    resultValid, 1);
      check("holdNotReady", frameReady,  0);
      frameValid = 1'b1;
      step();
    end
    frameValid = 1'b0;
    check("holdValidLast",  resultValid, 1);
    check("holdEnableLow",  layerEnable, 0);
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    checkIdle("afterHold", expectedCount);
  endtask

  initial begin
    // Reset state
    step();
    step();
    checkIdle("reset", 0);
    reset = 1'b1;
    step();
    checkIdle("postReset", 0);

    // Test 1: the reference frame timeline. Layers run for 5, 4 and 4 cycles,
    // and resultValid must appear 19 cycles after acceptance.
    acceptFrame();
    runLayer(0, 5, 3'b000);
    runLayer(1, 4, 3'b000);
    runLayer(2, 4, 3'b000);
    check("latencyToResult", cycle - acceptCycle, 19);
    check("resultValidRaised", resultValid, 1);

    // Test 2: HOLD stalls for 5 cycles with frameValid high, then resultReady.
    finishFrame(5, 1);
    step();
    check("noPhantomFrame", busy, 0);

    // Test 3: stray done bits (wrong layer, outside RUN) and an early
    // resultReady are all ignored. Layers run for 4, 1 and 2 cycles.
    resultReady = 1'b1;
    acceptFrame();
    runLayer(0, 4, 3'b110);
    resultReady = 1'b0;
    runLayer(1, 1, 3'b000);
    runLayer(2, 2, 3'b000);
    finishFrame(0, 2);

`ifdef TIMEOUT_EN
    // Test 4: the timeout fires after 16 RUN cycles, and errorClear recovers.
    acceptFrame();
    check("toClear", layerClear, 3'b001);
    step();
    for (int i = 0; i < timeoutCycles; i++) begin
      check("toRunEnable", layerEnable, 3'b001);
      check("toNoErrorYet", error, 0);
      step();
    end
    check("toError",       error,       1);
    check("toEnableLow",   layerEnable, 0);
    check("toNotReady",    frameReady,  0);
    check("toBusy",        busy,        1);
    frameValid = 1'b1;
    step();
    frameValid = 1'b0;
    check("toErrorSticky", error, 1);
    errorClear = 1'b1;
    step();
    errorClear = 1'b0;
    checkIdle("afterErrorClear", 2);
    // Done arriving in the limit cycle wins over the timeout.
    acceptFrame();
    runLayer(0, timeoutCycles, 3'b000);
    check("doneBeatsTimeout", error, 0);
    runLayer(1, 1, 3'b000);
    runLayer(2, 1, 3'b000);
    finishFrame(0, 3);
`else
    // Test 4 (timeout not built in): RUN waits past 16 cycles and errorClear is ignored.
    errorClear = 1'b1;
    acceptFrame();
    runLayer(0, 20, 3'b000);
    check("noTimeoutError", error, 0);
    errorClear = 1'b0;
    runLayer(1, 1, 3'b000);
    runLayer(2, 1, 3'b000);
    finishFrame(0, 3);
`endif

    // Test 5: reset asserted during the RUN of layer 1.
    acceptFrame();
    runLayer(0, 2, 3'b000);
    check("preResetClear1", layerClear, 3'b010);
    step();
    check("preResetEnable1", layerEnable, 3'b010);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkIdle("midRunReset", 0);

    // Test 6: four frames with countWidth=2 give frameCount 1, 2, 3, 0.
    for (int f = 1; f <= 4; f++) begin
      acceptFrame();
      runLayer(0, 1, 3'b000);
      runLayer(1, 1, 3'b000);
      runLayer(2, 1, 3'b000);
      finishFrame(0, f % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
    $finish;
  end

endmodule
